// File: rtl/serpent_pkg.sv
// Shared Serpent definitions: S-box tables (forward and inverse), the
// substitution-unit state encoding and bitsliced column helpers.
package serpent_pkg;

  localparam int BLOCK_W = 128;
  localparam int COLS    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward Serpent S-boxes S0..S7
  localparam logic [3:0] FWD_SBOX [8][16] = '{
    '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
    '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4 },
    '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2 },
    '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
    '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
    '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1 },
    '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0 },
    '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6 }
  };

  // Inverse Serpent S-boxes InvS0..InvS7
  localparam logic [3:0] INV_SBOX [8][16] = '{
    '{4'd13, 4'd3,  4'd11, 4'd0,  4'd10, 4'd6,  4'd5,  4'd12, 4'd1,  4'd14, 4'd4,  4'd7,  4'd15, 4'd9,  4'd8,  4'd2 },
    '{4'd5,  4'd8,  4'd2,  4'd14, 4'd15, 4'd6,  4'd12, 4'd3,  4'd11, 4'd4,  4'd7,  4'd9,  4'd1,  4'd13, 4'd10, 4'd0 },
    '{4'd12, 4'd9,  4'd15, 4'd4,  4'd11, 4'd14, 4'd1,  4'd2,  4'd0,  4'd3,  4'd6,  4'd13, 4'd5,  4'd8,  4'd10, 4'd7 },
    '{4'd0,  4'd9,  4'd10, 4'd7,  4'd11, 4'd14, 4'd6,  4'd13, 4'd3,  4'd5,  4'd12, 4'd2,  4'd4,  4'd8,  4'd15, 4'd1 },
    '{4'd5,  4'd0,  4'd8,  4'd3,  4'd10, 4'd9,  4'd7,  4'd14, 4'd2,  4'd12, 4'd11, 4'd6,  4'd4,  4'd15, 4'd13, 4'd1 },
    '{4'd8,  4'd15, 4'd2,  4'd9,  4'd4,  4'd1,  4'd13, 4'd14, 4'd11, 4'd6,  4'd5,  4'd3,  4'd7,  4'd12, 4'd10, 4'd0 },
    '{4'd15, 4'd10, 4'd1,  4'd13, 4'd5,  4'd3,  4'd6,  4'd0,  4'd4,  4'd9,  4'd14, 4'd7,  4'd2,  4'd12, 4'd8,  4'd11},
    '{4'd3,  4'd0,  4'd6,  4'd13, 4'd9,  4'd14, 4'd15, 4'd8,  4'd5,  4'd12, 4'd11, 4'd7,  4'd10, 4'd1,  4'd4,  4'd2 }
  };

  // Gather column c of a bitsliced block; word 0 supplies the MSB.
  // Column c lives at bits c, c+32, c+64, c+96, i.e. {k, c} for word k.
  function automatic logic [3:0] get_col(input logic [BLOCK_W-1:0] w,
                                         input logic [4:0]         c);
    return {w[{2'b00, c}], w[{2'b01, c}], w[{2'b10, c}], w[{2'b11, c}]};
  endfunction

  // Scatter a nibble back into column c, leaving every other bit untouched.
  function automatic logic [BLOCK_W-1:0] put_col(input logic [BLOCK_W-1:0] w,
                                                 input logic [4:0]         c,
                                                 input logic [3:0]         nib);
    logic [BLOCK_W-1:0] r;
    r = w;
    r[{2'b00, c}] = nib[3];
    r[{2'b01, c}] = nib[2];
    r[{2'b10, c}] = nib[1];
    r[{2'b11, c}] = nib[0];
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox_nibble.sv
// One inverse Serpent S-box lane: a pure 4-bit table lookup.
module inv_sbox_nibble
  import serpent_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Table lookup selected by the latched S-box index
  always_comb begin
    nib_o = INV_SBOX[sel][nib_i];
  end

endmodule

// File: rtl/inv_s_box.sv
// Sequential inverse Serpent S-box unit. Accepts a bitsliced block, rewrites
// LANES nibble columns per clock in place, then holds the result until taken.
module inv_s_box
  import serpent_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         sel,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data
);

  localparam int N     = (LANES > 0) ? (COLS / LANES) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int LOG_L = (LANES > 1) ? $clog2(LANES) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if ((LANES < 1) || (LANES > COLS) || ((COLS % LANES) != 0)) begin : g_bad_lanes
    $error("inv_s_box: LANES=%0d does not divide %0d", LANES, COLS);
  end

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] work_q,  work_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [2:0]         sel_q,   sel_d;

  logic [4:0]         col_base;
  logic [LANES*5-1:0] lane_col;
  logic [LANES*4-1:0] lane_nib_in;
  logic [LANES*4-1:0] lane_nib_out;

  // Column addresses and source nibbles for the lanes active in this pass
  always_comb begin
    col_base    = 5'(cnt_q) << LOG_L;
    lane_col    = '0;
    lane_nib_in = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_col[l*5 +: 5]    = col_base + 5'(l);
      lane_nib_in[l*4 +: 4] = get_col(work_q, lane_col[l*5 +: 5]);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox_nibble u_nib (
      .sel   (sel_q),
      .nib_i (lane_nib_in[g*4 +: 4]),
      .nib_o (lane_nib_out[g*4 +: 4])
    );
  end

  // Next-state logic: load on accept, substitute in place, hold until taken
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          sel_d   = sel;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d = put_col(work_d, lane_col[l*5 +: 5], lane_nib_out[l*4 +: 4]);
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // Handshake outputs decode the registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = work_q;
  end

endmodule
